mux_readback_shifter: RTL and testbench

//   Read side of the mux-based register cells: captures a WIDTH-bit parallel

---
 rtl/mux_readback_shifter_if.sv | 25 ++
 rtl/mux_readback_shifter.sv | 100 ++++++++++
 tb/tb_mux_readback_shifter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_readback_shifter_if.sv
// Handshake/bus bundle between a register bank reader and the readback shifter.
// dbg_state mirrors the shifter FSM state for observation by checkers.
interface mux_readback_shifter_if #(
  parameter int WIDTH = 8
);
  logic             CAP_REQ;
  logic [WIDTH-1:0] PAR_IN;
  logic             SO_READY;
  logic             SO;
  logic             SO_VALID;
  logic             SO_LAST;
  logic             BUSY;
  logic             DONE;
  logic [1:0]       dbg_state;

  modport master (
    output CAP_REQ, PAR_IN, SO_READY,
    input  SO, SO_VALID, SO_LAST, BUSY, DONE, dbg_state
  );

  modport slave (
    input  CAP_REQ, PAR_IN, SO_READY,
    output SO, SO_VALID, SO_LAST, BUSY, DONE, dbg_state
  );
endinterface

// File: rtl/mux_readback_shifter.sv
// Captures a parallel register word and serialises it onto a 1-bit stream,
// optionally followed by an even-parity bit.
module mux_readback_shifter #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0,
  parameter int PARITY    = 1
) (
  input logic                   CLK,
  input logic                   AL,
  mux_readback_shifter_if.slave bus
);

  localparam int N  = WIDTH + PARITY;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_PAR  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             par_q, par_d;
  logic             xfer;
  logic             data_bit;

  // Handshake: a bit moves when SO_VALID and SO_READY are both high at a
  // rising edge; while SO_READY is low the current bit is held unchanged.
  always_ff @(posedge CLK or posedge AL) begin
    if (AL) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    xfer    = (state_q == ST_SHIFT) && bus.SO_READY;
    case (state_q)
      ST_IDLE: begin
        if (bus.CAP_REQ) begin
          shreg_d = bus.PAR_IN;
          cnt_d   = '0;
          par_d   = ^bus.PAR_IN;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (xfer) begin
          shreg_d = (LSB_FIRST != 0) ? (shreg_q >> 1) : (shreg_q << 1);
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output end of the shift register; the parity slot follows the data bits.
  assign data_bit = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[WIDTH-1];

  always_comb begin
    bus.SO       = 1'b0;
    bus.SO_VALID = 1'b0;
    bus.SO_LAST  = 1'b0;
    bus.BUSY     = 1'b0;
    bus.DONE     = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        bus.SO_VALID = 1'b1;
        bus.BUSY     = 1'b1;
        bus.SO_LAST  = (cnt_q == CNT_LAST);
        bus.SO       = ((PARITY != 0) && (cnt_q == CNT_PAR)) ? par_q : data_bit;
      end
      ST_DONE: begin
        bus.BUSY = 1'b1;
        bus.DONE = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mux_readback_shifter.sv
// Bench for mux_readback_shifter: three configurations (MSB+parity,
// LSB+parity, MSB without parity) checked against hand-derived frames.
module tb_mux_readback_shifter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_readback_shifter_if #(.WIDTH(8)) m_if ();
  mux_readback_shifter_if #(.WIDTH(8)) l_if ();
  mux_readback_shifter_if #(.WIDTH(8)) p_if ();

  mux_readback_shifter #(.WIDTH(8), .LSB_FIRST(0), .PARITY(1)) dut_m (
    .CLK(clk), .AL(rst), .bus(m_if.slave));
  mux_readback_shifter #(.WIDTH(8), .LSB_FIRST(1), .PARITY(1)) dut_l (
    .CLK(clk), .AL(rst), .bus(l_if.slave));
  mux_readback_shifter #(.WIDTH(8), .LSB_FIRST(0), .PARITY(0)) dut_p (
    .CLK(clk), .AL(rst), .bus(p_if.slave));

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard entries are {SO_LAST, SO}.
  logic [1:0] exp_m[$];
  logic [1:0] exp_l[$];
  logic [1:0] exp_p[$];
  int         m_xfers = 0;
  int         cyc = 0;
  int         rise_cyc[$];
  logic       busy_prev = 1'b0;
  logic       stall_prev = 1'b0;
  logic [1:0] stall_val;

  typedef struct {
    int         sel;
    logic [7:0] par_in;
    logic [8:0] frame;
    int         nbits;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name, inout logic [1:0] q[$], input logic [1:0] act);
    logic [1:0] e;
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got unexpected bit %0h, expected none", name, act);
    end else begin
      e = q.pop_front();
      check(name, {30'd0, act}, {30'd0, e});
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst && m_if.SO_VALID && m_if.SO_READY) begin
      pop_check("m_bit", exp_m, {m_if.SO_LAST, m_if.SO});
      m_xfers++;
    end
    if (!rst && l_if.SO_VALID && l_if.SO_READY) pop_check("l_bit", exp_l, {l_if.SO_LAST, l_if.SO});
    if (!rst && p_if.SO_VALID && p_if.SO_READY) pop_check("p_bit", exp_p, {p_if.SO_LAST, p_if.SO});
    // A stalled bit must be presented unchanged on the next cycle.
    if (!rst && stall_prev)
      check("m_stall_hold", {29'd0, m_if.SO_VALID, m_if.SO_LAST, m_if.SO}, {29'd0, 1'b1, stall_val});
    stall_prev = !rst && m_if.SO_VALID && !m_if.SO_READY;
    stall_val  = {m_if.SO_LAST, m_if.SO};
    if (m_if.BUSY && !busy_prev) rise_cyc.push_back(cyc);
    busy_prev = m_if.BUSY;
  end

  function automatic logic [2:0] obs(input int sel);
    case (sel)
      0:       return {m_if.BUSY, m_if.DONE, m_if.SO_VALID};
      1:       return {l_if.BUSY, l_if.DONE, l_if.SO_VALID};
      default: return {p_if.BUSY, p_if.DONE, p_if.SO_VALID};
    endcase
  endfunction

  function automatic int qsize(input int sel);
    case (sel)
      0:       return exp_m.size();
      1:       return exp_l.size();
      default: return exp_p.size();
    endcase
  endfunction

  // frame[nbits-1] is the first bit on the wire.
  task automatic push_frame(input int sel, input logic [8:0] frame, input int nbits);
    logic [1:0] e;
    for (int i = nbits - 1; i >= 0; i--) begin
      e = {(i == 0), frame[i]};
      case (sel)
        0:       exp_m.push_back(e);
        1:       exp_l.push_back(e);
        default: exp_p.push_back(e);
      endcase
    end
  endtask

  task automatic set_cap(input int sel, input logic req, input logic [7:0] w);
    case (sel)
      0:       begin m_if.CAP_REQ = req; m_if.PAR_IN = w; end
      1:       begin l_if.CAP_REQ = req; l_if.PAR_IN = w; end
      default: begin p_if.CAP_REQ = req; p_if.PAR_IN = w; end
    endcase
  endtask

  // Returns just after the capture edge.
  task automatic capture(input int sel, input logic [7:0] w);
    @(posedge clk); #1;
    set_cap(sel, 1'b1, w);
    @(posedge clk); #1;
    set_cap(sel, 1'b0, 8'h00);
  endtask

  task automatic wait_done(input int sel, input string name);
    int guard;
    guard = 0;
    while (obs(sel)[1] !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_frame(input int sel, input logic [7:0] w, input logic [8:0] frame, input int nbits);
    int cnt;
    push_frame(sel, frame, nbits);
    capture(sel, w);
    @(negedge clk);
    check("first_valid", {29'd0, obs(sel)}, 32'b101);
    cnt = 1;
    while (obs(sel)[1] !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("done_latency", cnt, nbits + 1);
    @(negedge clk);
    check("idle_after_done", {29'd0, obs(sel)}, 32'd0);
    check("queue_drained", qsize(sel), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    int         base;
    int         guard;
    int         i;

    vecs[0] = '{0, 8'hA5, 9'b101001010, 9};
    vecs[1] = '{0, 8'h01, 9'b000000011, 9};
    vecs[2] = '{0, 8'h80, 9'b100000001, 9};
    vecs[3] = '{0, 8'h00, 9'b000000000, 9};
    vecs[4] = '{1, 8'h01, 9'b100000001, 9};
    vecs[5] = '{1, 8'h06, 9'b011000000, 9};
    vecs[6] = '{2, 8'hFF, 9'b011111111, 8};
    vecs[7] = '{2, 8'h81, 9'b010000001, 8};

    rst = 1'b1;
    for (int s = 0; s < 3; s++) set_cap(s, 1'b0, 8'h00);
    m_if.SO_READY = 1'b1;
    l_if.SO_READY = 1'b1;
    p_if.SO_READY = 1'b1;
    #2;
    check("reset_outputs", {m_if.SO, m_if.SO_LAST, m_if.dbg_state, obs(0)}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_outputs", {m_if.SO, m_if.SO_LAST, m_if.dbg_state, obs(0), obs(1), obs(2)}, 32'd0);

    for (int v = 0; v < 8; v++) run_frame(vecs[v].sel, vecs[v].par_in, vecs[v].frame, vecs[v].nbits);

    // Ready pattern 1,0,0,1 repeating: bits must neither drop nor repeat.
    pat  = 4'b1001;
    base = m_xfers;
    push_frame(0, 9'b101001010, 9);
    capture(0, 8'hA5);
    i = 0;
    guard = 0;
    while (m_if.DONE !== 1'b1 && guard < 200) begin
      m_if.SO_READY = pat[i % 4];
      i++;
      guard++;
      @(posedge clk); #1;
    end
    m_if.SO_READY = 1'b1;
    check("stall_xfer_count", m_xfers - base, 9);
    repeat (2) @(negedge clk);
    check("stall_queue_drained", exp_m.size(), 0);

    // CAP_REQ held high: back-to-back frames, PAR_IN change mid-frame ignored.
    push_frame(0, 9'b101001010, 9);
    push_frame(0, 9'b111111110, 9);
    rise_cyc.delete();
    @(posedge clk); #1;
    set_cap(0, 1'b1, 8'hA5);
    guard = 0;
    while (rise_cyc.size() < 1 && guard < 50) begin @(posedge clk); guard++; end
    #1 m_if.PAR_IN = 8'hFF;
    guard = 0;
    while (rise_cyc.size() < 2 && guard < 50) begin @(posedge clk); guard++; end
    #1 set_cap(0, 1'b0, 8'h00);
    if (rise_cyc.size() >= 2) check("frame_gap", rise_cyc[1] - rise_cyc[0], 11);
    else check("frame_gap_seen", rise_cyc.size(), 2);
    wait_done(0, "b2b");
    repeat (2) @(negedge clk);
    check("b2b_queue_drained", exp_m.size(), 0);
    check("b2b_no_third_frame", rise_cyc.size(), 2);

    // Abort after four transfers.
    push_frame(0, 9'b101001010, 9);
    repeat (5) void'(exp_m.pop_back());
    base = m_xfers;
    capture(0, 8'hA5);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("abort_outputs", {m_if.SO, m_if.SO_LAST, m_if.dbg_state, obs(0)}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("abort_no_done_in_reset", {31'd0, m_if.DONE}, 32'd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_idle", {29'd0, obs(0)}, 32'd0);
    end
    check("abort_xfers", m_xfers - base, 4);
    check("abort_queue_drained", exp_m.size(), 0);
    run_frame(0, 8'h3C, 9'b001111000, 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
